// File: rtl/dat_mem_param_if.sv
// Request/response bundle for dat_mem_param: one request channel with a ready
// handshake and a registered read-response channel with an address-error pulse.
interface dat_mem_param_if #(
  parameter int DW = 8,
  parameter int AW = 8
) ();

  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          addr_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, addr_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, addr_err
  );

endinterface

// File: rtl/dat_mem_param.sv
// Single-port data memory with 1-cycle registered reads and out-of-range error pulses.
// Define DAT_MEM_PARAM_CLEAR_EN to zero every word after reset before accepting requests.
module dat_mem_param #(
  parameter int DW    = 8,
  parameter int AW    = 8,
  parameter int DEPTH = 2**AW
) (
  input  logic            clk,
  input  logic            rst_n,
  dat_mem_param_if.slave  bus
);

  logic [DW-1:0] mem [DEPTH];

  logic          accept;
  logic          in_range;
  logic          clearing;

  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [DW-1:0] mem_wdata;

  logic          rsp_valid_q, rsp_valid_d;
  logic [DW-1:0] rsp_rdata_q, rsp_rdata_d;
  logic          addr_err_q,  addr_err_d;

  // A fully populated address space can never be out of range.
  if (DEPTH >= 2**AW) begin : g_full_depth
    assign in_range = 1'b1;
  end else begin : g_part_depth
    assign in_range = (bus.req_addr < AW'(DEPTH));
  end

`ifdef DAT_MEM_PARAM_CLEAR_EN
  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;
  localparam logic [AW-1:0] CLR_LAST = AW'(DEPTH - 1);

  logic [0:0]    state_q, state_d;
  logic [AW-1:0] clr_cnt_q, clr_cnt_d;

  // NOTE: every always_comb output gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    if (state_q == ST_INIT) begin
      if (clr_cnt_q == CLR_LAST) begin
        state_d = ST_RUN;
      end else begin
        clr_cnt_d = clr_cnt_q + 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; combinational blocks use blocking (=).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_INIT;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  assign clearing      = (state_q == ST_INIT);
  assign bus.req_ready = (state_q == ST_RUN);
`else
  // Ready tracks reset directly so a request held across release is taken on
  // the very first edge.
  assign clearing      = 1'b0;
  assign bus.req_ready = rst_n;
`endif

  assign accept = bus.req_valid & bus.req_ready;

  // The clear sweep owns the write port while it runs; otherwise in-range writes.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = bus.req_addr;
    mem_wdata = bus.req_wdata;
    if (clearing) begin
      mem_we    = 1'b1;
`ifdef DAT_MEM_PARAM_CLEAR_EN
      mem_waddr = clr_cnt_q;
`endif
      mem_wdata = '0;
    end else if (accept && bus.req_we && in_range) begin
      mem_we    = 1'b1;
    end
  end

  // NOTE: the storage array has no reset; it maps onto plain RAM and any
  // required initial contents come from the clear sweep instead.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  always_comb begin
    rsp_valid_d = accept & ~bus.req_we;
    addr_err_d  = accept & ~in_range;
    rsp_rdata_d = rsp_rdata_q;
    if (rsp_valid_d) begin
      rsp_rdata_d = in_range ? mem[bus.req_addr] : '0;
    end
  end

  // Reset drops any read still in flight, so no stale response follows release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      addr_err_q  <= 1'b0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      addr_err_q  <= addr_err_d;
    end
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.addr_err  = addr_err_q;

endmodule

// File: tb/tb_dat_mem_param.sv
// Self-checking bench for dat_mem_param (DEPTH=200) against an array-based model;
// covers both builds depending on DAT_MEM_PARAM_CLEAR_EN.
module tb_dat_mem_param;

  localparam int DW    = 8;
  localparam int AW    = 8;
  localparam int DEPTH = 200;
`ifdef DAT_MEM_PARAM_CLEAR_EN
  localparam bit CLEAR = 1'b1;
`else
  localparam bit CLEAR = 1'b0;
`endif
  localparam int INIT_CYC = CLEAR ? DEPTH : 0;

  logic clk;
  logic rst_n;

  dat_mem_param_if #(.DW(DW), .AW(AW)) bus ();

  dat_mem_param #(.DW(DW), .AW(AW), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total;
  int bad;
  int edges;
  logic [DW-1:0] ref_mem [256];
  bit            known   [256];
  logic [DW-1:0] last_rdata;
  bit            rdata_known;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Model view of a freshly released block: cleared build reads zero everywhere.
  task automatic model_reset();
    edges       = 0;
    last_rdata  = '0;
    rdata_known = 1'b1;
    for (int i = 0; i < 256; i++) begin
      ref_mem[i] = '0;
      known[i]   = CLEAR;
    end
  endtask

  task automatic check_in_reset(input string tag);
    check({tag, " req_ready"}, 32'(bus.req_ready), 32'd0);
    check({tag, " rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
    check({tag, " rsp_rdata"}, 32'(bus.rsp_rdata), 32'd0);
    check({tag, " addr_err"},  32'(bus.addr_err),  32'd0);
  endtask

  // One clock of traffic: present inputs, step one edge, compare with the model.
  task automatic do_req(input bit v, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bit exp_ready;
    bit acc;
    bus.req_valid = v;
    bus.req_we    = we;
    bus.req_addr  = a;
    bus.req_wdata = d;
    exp_ready = (edges >= INIT_CYC);
    check($sformatf("req_ready@edge%0d", edges), 32'(bus.req_ready), 32'(exp_ready));
    acc = v && exp_ready;
    @(posedge clk);
    edges++;
    #1;
    if (acc && we && int'(a) < DEPTH) begin
      ref_mem[a] = d;
      known[a]   = 1'b1;
    end
    if (acc && !we) begin
      if (int'(a) < DEPTH) begin
        last_rdata  = ref_mem[a];
        rdata_known = known[a];
      end else begin
        last_rdata  = '0;
        rdata_known = 1'b1;
      end
    end
    check($sformatf("rsp_valid a=%0h", a), 32'(bus.rsp_valid), 32'(acc && !we));
    check($sformatf("addr_err a=%0h", a),  32'(bus.addr_err),  32'(acc && int'(a) >= DEPTH));
    if (rdata_known) begin
      check($sformatf("rsp_rdata a=%0h", a), 32'(bus.rsp_rdata), 32'(last_rdata));
    end
  endtask

  task automatic run_init();
    while (edges < INIT_CYC) begin
      do_req(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom));
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    total = 0;
    bad   = 0;
    model_reset();
    rst_n         = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;

    repeat (2) @(posedge clk);
    #1;
    check_in_reset("reset");

    // Request held across release: taken on the first edge when clearing is off.
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_addr  = 8'h00;
    bus.req_wdata = 8'h3C;
    model_reset();
    rst_n = 1'b1;
    do_req(1'b1, 1'b1, 8'h00, 8'h3C);
    do_req(1'b1, 1'b0, 8'h00, 8'h00);

    run_init();
    do_req(1'b1, 1'b0, 8'h7F, 8'h00);

    // Read immediately after a write to the same word.
    do_req(1'b1, 1'b1, 8'h10, 8'hA5);
    do_req(1'b1, 1'b0, 8'h10, 8'h00);

    // Back-to-back reads.
    do_req(1'b1, 1'b1, 8'h01, 8'h11);
    do_req(1'b1, 1'b1, 8'h02, 8'h22);
    do_req(1'b1, 1'b1, 8'h03, 8'h33);
    do_req(1'b1, 1'b0, 8'h01, 8'h00);
    do_req(1'b1, 1'b0, 8'h02, 8'h00);
    do_req(1'b1, 1'b0, 8'h03, 8'h00);

    // Idle cycles: response drops, read data holds.
    repeat (3) do_req(1'b0, 1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom));

    // Out-of-range accesses must not disturb any implemented word.
    for (int a = 0; a < DEPTH; a++) do_req(1'b1, 1'b1, 8'(a), 8'($urandom));
    do_req(1'b1, 1'b1, 8'hC8, 8'hFF);
    do_req(1'b1, 1'b0, 8'hC8, 8'h00);
    do_req(1'b1, 1'b1, 8'hFF, 8'hEE);
    do_req(1'b1, 1'b0, 8'hFF, 8'h00);
    for (int a = 0; a < DEPTH; a++) do_req(1'b1, 1'b0, 8'(a), 8'h00);

    repeat (400) begin
      do_req(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
             8'($urandom_range(0, 255)), 8'($urandom));
    end

    // Reset between a read's acceptance and its response window.
    do_req(1'b1, 1'b1, 8'h05, 8'h5A);
    do_req(1'b1, 1'b0, 8'h05, 8'h00);
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b0;
    rst_n = 1'b0;
    #1;
    check_in_reset("mid-run reset");
    @(posedge clk);
    #1;
    check_in_reset("held reset");
    model_reset();
    rst_n = 1'b1;
    do_req(1'b0, 1'b0, 8'h05, 8'h00);
    do_req(1'b0, 1'b0, 8'h05, 8'h00);
    run_init();
    do_req(1'b1, 1'b0, 8'h10, 8'h00);
    do_req(1'b1, 1'b1, 8'h20, 8'hC3);
    do_req(1'b1, 1'b0, 8'h20, 8'h00);
    do_req(1'b0, 1'b0, 8'h00, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dat_mem_param.md
DAT_MEM_PARAM -- requirements
Module: dat_mem_param

Interface
REQ-001 Parameter DW, default 8, data word width in bits.
REQ-002 Parameter AW, default 8, address width in bits.
REQ-003 Parameter DEPTH, default 2**AW, number of words implemented; legal range 1..2**AW.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 req_valid  input  1  request present this cycle.
REQ-007 req_ready  output  1  block accepts a request this cycle.
REQ-008 req_we  input  1  1 = write, 0 = read.
REQ-009 req_addr  input  AW  word address.
REQ-010 req_wdata  input  DW  write data.
REQ-011 rsp_valid  output  1  one-cycle pulse: read data valid.
REQ-012 rsp_rdata  output  DW  read data, registered.
REQ-013 addr_err  output  1  one-cycle pulse: accepted request addressed >= DEPTH.

Function
REQ-014 Request accepted on a rising edge where req_valid and req_ready are both 1; otherwise req_* ignored.
REQ-015 At most one request per cycle; back-to-back acceptance every cycle while req_ready=1.
REQ-016 Write: memory word updated at the accepting edge; no response generated.
REQ-017 Read: rsp_valid=1 and rsp_rdata=word exactly one cycle after acceptance (latency 1).
REQ-018 rsp_rdata holds its last value until the next accepted read; rsp_valid is 0 in all other cycles.
REQ-019 Read accepted the cycle after a write to the same address returns the newly written data.
REQ-020 Address >= DEPTH: write discarded, read returns rsp_rdata=0 with rsp_valid=1; addr_err=1 the cycle after acceptance in both cases.
REQ-021 State machine: INIT (clearing, req_ready=0) -> RUN (req_ready=1) when the clear counter reaches DEPTH-1; RUN is terminal until reset.
REQ-022 INIT writes 0 to one word per cycle, address 0 upward, taking exactly DEPTH cycles.
REQ-023 Requests presented during INIT are not accepted and produce no response or error.

Reset
REQ-024 rst_n=0 forces immediately: state INIT, clear counter 0, req_ready=0, rsp_valid=0, rsp_rdata=0, addr_err=0.
REQ-025 Reset asserted mid-operation (INIT or RUN) abandons any pending read response; no rsp_valid after release for a request accepted before reset.
REQ-026 After rst_n rises, clearing starts on the first rising edge.

Configuration
REQ-027 Macro DAT_MEM_PARAM_CLEAR_EN defined: INIT clearing per REQ-021..REQ-023; all words read 0 until written.
REQ-028 Macro DAT_MEM_PARAM_CLEAR_EN undefined: no INIT state or counter; req_ready=1 from the first rising edge after reset release; memory contents undefined until written.

Verification
REQ-029 Clear on, DW=8 AW=8 DEPTH=256: release reset -> req_ready=0 for 256 cycles then 1; read addr 0x7F -> rsp_rdata=0x00 next cycle.
REQ-030 Write 0xA5 @0x10 then read @0x10 in the immediately following cycle -> rsp_valid=1, rsp_rdata=0xA5 one cycle after the read.
REQ-031 Reads @0x01,0x02,0x03 on consecutive cycles after writing 0x11,0x22,0x33 -> rsp_valid high 3 consecutive cycles with 0x11,0x22,0x33.
REQ-032 DEPTH=200: write 0xFF @0xC8, then read @0xC8 -> addr_err pulses after each; read gives rsp_rdata=0x00; @0x00..0xC7 unchanged.
REQ-033 Read @0x05 accepted, rst_n low before next edge -> rsp_valid stays 0, rsp_rdata=0, req_ready=0; clearing restarts after release.
REQ-034 Clear off: req_valid held during reset release -> request accepted on first edge; write-then-read 0x3C @0x00 returns 0x3C.
